// File: rtl/tx_arbiter_if.sv
// Bus bundle between the tx_arbiter, its packet/command sources and the escaping UART-TX stage.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   REQ_VALID_I;
  logic [8*NUM_REQ-1:0] REQ_DATA_I;
  logic [NUM_REQ-1:0]   REQ_LAST_I;
  logic [NUM_REQ-1:0]   REQ_READY_O;
  logic                 CMD_VALID_I;
  logic [7:0]           CMD_I;
  logic                 CMD_READY_O;
  logic                 TX_READY_I;
  logic [7:0]           DATA_SEND_O;
  logic                 WRITE_O;
  logic [7:0]           COMMAND_O;
  logic                 WRITE_COMMAND_O;
  logic [NUM_REQ-1:0]   GRANT_O;
  logic                 BUSY_O;
  logic                 TIMEOUT_O;

  modport slave (
    input  REQ_VALID_I, REQ_DATA_I, REQ_LAST_I, CMD_VALID_I, CMD_I, TX_READY_I,
    output REQ_READY_O, CMD_READY_O, DATA_SEND_O, WRITE_O, COMMAND_O,
           WRITE_COMMAND_O, GRANT_O, BUSY_O, TIMEOUT_O
  );

  modport master (
    output REQ_VALID_I, REQ_DATA_I, REQ_LAST_I, CMD_VALID_I, CMD_I, TX_READY_I,
    input  REQ_READY_O, CMD_READY_O, DATA_SEND_O, WRITE_O, COMMAND_O,
           WRITE_COMMAND_O, GRANT_O, BUSY_O, TIMEOUT_O
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one byte at a time into the escaping UART-TX stage.
// Optional stall timeout for a locked requester is enabled with the TX_ARB_TIMEOUT_EN macro.
module tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  tx_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               lock_q, lock_d;
  logic [PTR_W-1:0]   lockIdx_q, lockIdx_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [7:0]         byte_q, byte_d;
  logic               isCmd_q, isCmd_d;
  logic               last_q, last_d;

  logic [NUM_REQ-1:0] reqReady;
  logic               cmdReady;
  logic               wrData;
  logic               wrCmd;
  logic               pickFound;
  logic [PTR_W-1:0]   pickIdx;
  logic [PTR_W-1:0]   lockNext;
  logic [NUM_REQ-1:0] grant;
  logic               timeoutRelease;
  int                 idx;

  // Walk offsets from the far end so the requester nearest the rr pointer is assigned last and wins.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    idx       = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(rrPtr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.REQ_VALID_I[idx]) begin
        pickFound = 1'b1;
        pickIdx   = PTR_W'(idx);
      end
    end
  end

  assign lockNext = (int'(lockIdx_q) == NUM_REQ - 1) ? '0 : lockIdx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    lockIdx_d = lockIdx_q;
    rrPtr_d   = rrPtr_q;
    byte_d    = byte_q;
    isCmd_d   = isCmd_q;
    last_d    = last_q;
    reqReady  = '0;
    cmdReady  = 1'b0;
    wrData    = 1'b0;
    wrCmd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lock_q) begin
          if (bus.CMD_VALID_I) begin
            cmdReady = 1'b1;
            byte_d   = bus.CMD_I;
            isCmd_d  = 1'b1;
            last_d   = 1'b0;
            state_d  = SEND;
          end else if (pickFound) begin
            reqReady[pickIdx] = 1'b1;
            byte_d    = bus.REQ_DATA_I[8*pickIdx +: 8];
            last_d    = bus.REQ_LAST_I[pickIdx];
            isCmd_d   = 1'b0;
            lock_d    = 1'b1;
            lockIdx_d = pickIdx;
            state_d   = SEND;
          end
        end else if (bus.REQ_VALID_I[lockIdx_q]) begin
          reqReady[lockIdx_q] = 1'b1;
          byte_d  = bus.REQ_DATA_I[8*lockIdx_q +: 8];
          last_d  = bus.REQ_LAST_I[lockIdx_q];
          isCmd_d = 1'b0;
          state_d = SEND;
        end else if (timeoutRelease) begin
          lock_d  = 1'b0;
          rrPtr_d = lockNext;
        end
      end
      SEND: begin
        if (bus.TX_READY_I) begin
          wrData  = !isCmd_q;
          wrCmd   = isCmd_q;
          state_d = HOLD;
        end
      end
      // The escape stage drops ready one cycle after a write, so ready is not trusted here.
      HOLD: state_d = WAIT;
      WAIT: begin
        if (bus.TX_READY_I) begin
          state_d = IDLE;
          if (!isCmd_q && last_q) begin
            lock_d  = 1'b0;
            rrPtr_d = lockNext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      lock_q    <= 1'b0;
      lockIdx_q <= '0;
      rrPtr_q   <= '0;
      byte_q    <= '0;
      isCmd_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      lockIdx_q <= lockIdx_d;
      rrPtr_q   <= rrPtr_d;
      byte_q    <= byte_d;
      isCmd_q   <= isCmd_d;
      last_q    <= last_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             stalled;

  always_comb begin
    stalled        = (state_q == IDLE) && lock_q && !bus.REQ_VALID_I[lockIdx_q];
    timeoutRelease = stalled && (timer_q == TMR_W'(TIMEOUT - 1));
    timer_d        = (stalled && !timeoutRelease) ? timer_q + 1'b1 : '0;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign bus.TIMEOUT_O = timeoutRelease & ~RST_I;
`else
  assign timeoutRelease = 1'b0;
  assign bus.TIMEOUT_O  = 1'b0;
`endif

  always_comb begin
    grant = '0;
    if (lock_q) grant[lockIdx_q] = 1'b1;
  end

  // Combinational handshakes are forced low while reset is held so nothing leaks out mid-reset.
  assign bus.REQ_READY_O     = RST_I ? '0 : reqReady;
  assign bus.CMD_READY_O     = cmdReady & ~RST_I;
  assign bus.WRITE_O         = wrData & ~RST_I;
  assign bus.WRITE_COMMAND_O = wrCmd & ~RST_I;
  assign bus.DATA_SEND_O     = (state_q == SEND && !isCmd_q) ? byte_q : 8'h00;
  assign bus.COMMAND_O       = (state_q == SEND && isCmd_q) ? byte_q : 8'h00;
  assign bus.GRANT_O         = grant;
  assign bus.BUSY_O          = (state_q != IDLE) || lock_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized packet/command traffic
// checked against a packet-level model of round-robin order and between-packet command insertion.
module tb_tx_arbiter;

  localparam int NREQ = 2;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [24:0] outsNow;
  assign outsNow = {bus.REQ_READY_O, bus.CMD_READY_O, bus.DATA_SEND_O, bus.WRITE_O, bus.COMMAND_O,
                    bus.WRITE_COMMAND_O, bus.GRANT_O, bus.BUSY_O, bus.TIMEOUT_O};

  logic [8:0] outQ[$];
  logic [8:0] reqQ[NREQ][$];
  logic [7:0] cmdQ[$];
  int         cmdTrig[$];
  int         cycNow = 0;
  int         lastStrobe = -100;

  // Records every strobe as {isCmd, byte} and checks strobe exclusivity and minimum byte spacing.
  always @(negedge clk) begin
    cycNow++;
    if (rst) begin
      lastStrobe = -100;
    end else if (bus.WRITE_O || bus.WRITE_COMMAND_O) begin
      outQ.push_back({bus.WRITE_COMMAND_O, bus.WRITE_COMMAND_O ? bus.COMMAND_O : bus.DATA_SEND_O});
      checks++;
      if (bus.WRITE_O && bus.WRITE_COMMAND_O) begin
        errors++;
        $display("[TB] FAIL strobe_exclusive: WRITE_O=%b WRITE_COMMAND_O=%b, required not both", bus.WRITE_O, bus.WRITE_COMMAND_O);
      end
      if (lastStrobe >= 0) begin
        checks++;
        if (cycNow - lastStrobe < 4) begin
          errors++;
          $display("[TB] FAIL byte_spacing: gap=%0d cycles, required >=4", cycNow - lastStrobe);
        end
      end
      lastStrobe = cycNow;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idleInputs();
    bus.REQ_VALID_I = '0;
    bus.REQ_DATA_I  = '0;
    bus.REQ_LAST_I  = '0;
    bus.CMD_VALID_I = 1'b0;
    bus.CMD_I       = 8'h00;
    bus.TX_READY_I  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    outQ.delete();
  endtask

  task automatic stepToDrive();
    @(posedge clk);
    #1;
  endtask

  // Feeds the queued packets/commands, raising each command once enough data bytes were accepted.
  task automatic driveTraffic(input bit randReady, input int maxCycles, input int expTotal);
    int cyc = 0;
    int accepted = 0;
    bit cmdActive = 1'b0;
    logic [NREQ-1:0] acc;
    bit cmdAcc;
    bit done = 1'b0;
    while (cyc < maxCycles && !done) begin
      for (int r = 0; r < NREQ; r++) begin
        bus.REQ_VALID_I[r] = (reqQ[r].size() > 0);
        bus.REQ_DATA_I[8*r +: 8] = (reqQ[r].size() > 0) ? reqQ[r][0][7:0] : 8'h00;
        bus.REQ_LAST_I[r] = (reqQ[r].size() > 0) ? reqQ[r][0][8] : 1'b0;
      end
      if (!cmdActive && cmdQ.size() > 0 && accepted >= cmdTrig[0]) begin
        cmdActive = 1'b1;
        bus.CMD_I = cmdQ[0];
        bus.CMD_VALID_I = 1'b1;
      end
      bus.TX_READY_I = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = bus.REQ_READY_O & bus.REQ_VALID_I;
      cmdAcc = bus.CMD_READY_O & bus.CMD_VALID_I;
      stepToDrive();
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r]) begin
          void'(reqQ[r].pop_front());
          accepted++;
        end
      end
      if (cmdAcc) begin
        void'(cmdQ.pop_front());
        void'(cmdTrig.pop_front());
        cmdActive = 1'b0;
        bus.CMD_VALID_I = 1'b0;
      end
      cyc++;
      done = (reqQ[0].size() == 0) && (reqQ[1].size() == 0) && (cmdQ.size() == 0) &&
             !cmdActive && (outQ.size() >= expTotal) && !bus.BUSY_O;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL traffic_drain: not drained after %0d cycles, outputs=%0d required=%0d", cyc, outQ.size(), expTotal);
    end
    idleInputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.REQ_VALID_I = '1;
    bus.REQ_DATA_I  = 16'hA55A;
    bus.REQ_LAST_I  = '1;
    bus.CMD_VALID_I = 1'b1;
    bus.CMD_I       = 8'h33;
    bus.TX_READY_I  = 1'b1;
    @(negedge clk);
    checks++;
    if (outsNow !== 25'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_active: got %h, required 0", outsNow);
    end
    doReset();
    @(negedge clk);
    checks++;
    if (outsNow !== 25'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_idle: got %h, required 0", outsNow);
    end
    stepToDrive();
  endtask

  task automatic test_single_byte();
    bus.REQ_VALID_I = 2'b01;
    bus.REQ_DATA_I  = 16'h0041;
    bus.REQ_LAST_I  = 2'b01;
    bus.TX_READY_I  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.REQ_READY_O !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_accept: REQ_READY_O=%b, required 01", bus.REQ_READY_O);
    end
    stepToDrive();
    bus.REQ_VALID_I = '0;
    @(negedge clk);
    checks++;
    if (bus.WRITE_O !== 1'b1 || bus.DATA_SEND_O !== 8'h41) begin
      errors++;
      $display("[TB] FAIL single_write: WRITE_O=%b DATA_SEND_O=%h, required 1/41", bus.WRITE_O, bus.DATA_SEND_O);
    end
    checks++;
    if (bus.GRANT_O !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_grant: GRANT_O=%b, required 01", bus.GRANT_O);
    end
    stepToDrive();
    @(negedge clk);
    checks++;
    if (bus.WRITE_O !== 1'b0 || bus.DATA_SEND_O !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_hold: WRITE_O=%b DATA_SEND_O=%h, required 0/00", bus.WRITE_O, bus.DATA_SEND_O);
    end
    stepToDrive();
    stepToDrive();
    @(negedge clk);
    checks++;
    if (bus.GRANT_O !== 2'b00 || bus.BUSY_O !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_release: GRANT_O=%b BUSY_O=%b, required 00/0", bus.GRANT_O, bus.BUSY_O);
    end
    stepToDrive();
    outQ.delete();
  endtask

  task automatic test_ready_stall();
    int badCycles = 0;
    bus.TX_READY_I  = 1'b0;
    bus.REQ_VALID_I = 2'b10;
    bus.REQ_DATA_I  = 16'h9C00;
    bus.REQ_LAST_I  = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.REQ_READY_O !== 2'b10) begin
      errors++;
      $display("[TB] FAIL stall_accept_rr: REQ_READY_O=%b, required 10", bus.REQ_READY_O);
    end
    stepToDrive();
    bus.REQ_VALID_I = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.WRITE_O !== 1'b0 || bus.DATA_SEND_O !== 8'h9C) badCycles++;
      stepToDrive();
    end
    checks++;
    if (badCycles != 0) begin
      errors++;
      $display("[TB] FAIL stall_hold: %0d bad cycles, required 0 (no strobe, byte 9c stable)", badCycles);
    end
    bus.TX_READY_I = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.WRITE_O !== 1'b1 || bus.DATA_SEND_O !== 8'h9C) begin
      errors++;
      $display("[TB] FAIL stall_release_write: WRITE_O=%b DATA_SEND_O=%h, required 1/9c", bus.WRITE_O, bus.DATA_SEND_O);
    end
    stepToDrive();
    @(negedge clk);
    checks++;
    if (bus.WRITE_O !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_single_strobe: WRITE_O=%b, required 0", bus.WRITE_O);
    end
    stepToDrive();
    stepToDrive();
    outQ.delete();
  endtask

  task automatic test_round_robin();
    logic [8:0] expv[$];
    doReset();
    reqQ[0] = '{9'h010, 9'h111, 9'h012, 9'h113};
    reqQ[1] = '{9'h020, 9'h121, 9'h022, 9'h123};
    expv = '{9'h010, 9'h011, 9'h020, 9'h021, 9'h012, 9'h013, 9'h022, 9'h023};
    driveTraffic(1'b0, 500, expv.size());
    checks++;
    if (outQ.size() != expv.size()) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d bytes, required %0d", outQ.size(), expv.size());
    end
    for (int i = 0; i < expv.size() && i < outQ.size(); i++) begin
      checks++;
      if (outQ[i] !== expv[i]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got %h, required %h", i, outQ[i], expv[i]);
      end
    end
  endtask

  task automatic test_command_between();
    logic [8:0] expv[$];
    doReset();
    reqQ[0] = '{9'h0A0, 9'h0A1, 9'h1A2};
    reqQ[1] = '{9'h0B0, 9'h1B1};
    cmdQ    = '{8'h05};
    cmdTrig = '{1};
    expv = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h105, 9'h0B0, 9'h0B1};
    driveTraffic(1'b0, 500, expv.size());
    checks++;
    if (outQ.size() != expv.size()) begin
      errors++;
      $display("[TB] FAIL cmd_count: got %0d items, required %0d", outQ.size(), expv.size());
    end
    for (int i = 0; i < expv.size() && i < outQ.size(); i++) begin
      checks++;
      if (outQ[i] !== expv[i]) begin
        errors++;
        $display("[TB] FAIL cmd_order[%0d]: got %h, required %h", i, outQ[i], expv[i]);
      end
    end
  endtask

  // Every requester always has a packet pending, so whole packets must come out strictly in turn.
  task automatic test_random_traffic();
    for (int iter = 0; iter < 3; iter++) begin
      logic [8:0] expData[$];
      logic [7:0] expCmd[$];
      int total = 0;
      int di = 0;
      int ci = 0;
      int t0;
      doReset();
      for (int p = 0; p < 3; p++) begin
        for (int r = 0; r < NREQ; r++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            logic [8:0] v;
            v = {(b == len - 1), 8'($urandom)};
            reqQ[r].push_back(v);
            expData.push_back(v);
            total++;
          end
        end
      end
      t0 = $urandom_range(0, total / 2);
      expCmd = '{8'($urandom), 8'($urandom)};
      cmdQ = expCmd;
      cmdTrig = '{t0, t0 + $urandom_range(0, total / 2)};
      driveTraffic(1'b1, 3000, total + 2);
      foreach (outQ[i]) begin
        checks++;
        if (outQ[i][8]) begin
          if (ci >= expCmd.size() || outQ[i][7:0] !== expCmd[ci] || !(di == 0 || expData[di-1][8])) begin
            errors++;
            $display("[TB] FAIL rand_cmd[%0d]: got %h after data #%0d, required next command at a packet boundary", i, outQ[i][7:0], di);
          end
          ci++;
        end else begin
          if (di >= expData.size() || outQ[i][7:0] !== expData[di][7:0]) begin
            errors++;
            $display("[TB] FAIL rand_data[%0d]: got %h, required %h", i, outQ[i][7:0], (di < expData.size()) ? expData[di][7:0] : 8'hxx);
          end
          di++;
        end
      end
      checks++;
      if (di != expData.size() || ci != expCmd.size()) begin
        errors++;
        $display("[TB] FAIL rand_totals: data=%0d cmds=%0d, required %0d/%0d", di, ci, expData.size(), expCmd.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    bus.REQ_VALID_I = 2'b01;
    bus.REQ_DATA_I  = 16'h0077;
    bus.REQ_LAST_I  = 2'b00;
    bus.TX_READY_I  = 1'b1;
    stepToDrive();
    bus.REQ_VALID_I = '0;
    stepToDrive();
    bus.TX_READY_I = 1'b0;
    stepToDrive();
    @(negedge clk);
    checks++;
    if (bus.BUSY_O !== 1'b1 || bus.GRANT_O !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midrst_in_wait: BUSY_O=%b GRANT_O=%b, required 1/01", bus.BUSY_O, bus.GRANT_O);
    end
    stepToDrive();
    rst = 1'b1;
    outQ.delete();
    bus.TX_READY_I  = 1'b1;
    bus.REQ_VALID_I = 2'b11;
    bus.REQ_DATA_I  = 16'h5A66;
    bus.REQ_LAST_I  = 2'b11;
    #1;
    checks++;
    if (outsNow !== 25'h0) begin
      errors++;
      $display("[TB] FAIL midrst_immediate: outputs=%h, required 0", outsNow);
    end
    stepToDrive();
    rst = 1'b0;
    bus.REQ_VALID_I = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.REQ_READY_O !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midrst_grant_req1: REQ_READY_O=%b, required 10", bus.REQ_READY_O);
    end
    stepToDrive();
    bus.REQ_VALID_I = '0;
    @(negedge clk);
    checks++;
    if (bus.WRITE_O !== 1'b1 || bus.DATA_SEND_O !== 8'h5A || bus.GRANT_O !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midrst_write: WRITE_O=%b DATA_SEND_O=%h GRANT_O=%b, required 1/5a/10", bus.WRITE_O, bus.DATA_SEND_O, bus.GRANT_O);
    end
    repeat (4) stepToDrive();
    checks++;
    if (outQ.size() != 1 || outQ[0] !== 9'h05A) begin
      errors++;
      $display("[TB] FAIL midrst_no_resend: %0d strobes first=%h, required exactly 1 of 05a", outQ.size(), (outQ.size() > 0) ? outQ[0] : 9'h0);
    end
  endtask

  task automatic test_timeout();
    int pulseAt = -1;
    int pulses = 0;
    int grantAt = -1;
    doReset();
    bus.REQ_VALID_I = 2'b01;
    bus.REQ_DATA_I  = 16'h0031;
    bus.REQ_LAST_I  = 2'b00;
    bus.TX_READY_I  = 1'b1;
    stepToDrive();
    bus.REQ_VALID_I = 2'b10;
    bus.REQ_DATA_I  = 16'h6200;
    bus.REQ_LAST_I  = 2'b10;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.TIMEOUT_O === 1'b1) begin
        pulses++;
        if (pulseAt < 0) pulseAt = i;
      end
      if (grantAt < 0 && bus.REQ_READY_O[1] === 1'b1) grantAt = i;
      stepToDrive();
      if (grantAt > 0) bus.REQ_VALID_I = '0;
    end
`ifdef TX_ARB_TIMEOUT_EN
    checks++;
    if (pulses != 1 || pulseAt != 3 + TMO) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: %0d pulses first at cycle %0d, required 1 at %0d", pulses, pulseAt, 3 + TMO);
    end
    checks++;
    if (grantAt != 4 + TMO) begin
      errors++;
      $display("[TB] FAIL timeout_next_grant: REQ1 accepted at cycle %0d, required %0d", grantAt, 4 + TMO);
    end
`else
    checks++;
    if (pulses != 0 || grantAt != -1) begin
      errors++;
      $display("[TB] FAIL lock_held: pulses=%0d REQ1 accept cycle=%0d, required 0/-1", pulses, grantAt);
    end
    checks++;
    if (bus.GRANT_O !== 2'b01) begin
      errors++;
      $display("[TB] FAIL lock_grant: GRANT_O=%b, required 01", bus.GRANT_O);
    end
`endif
    doReset();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_single_byte();
    test_ready_stall();
    test_round_robin();
    test_command_between();
    test_random_traffic();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
